// File: rtl/c_wrr_packet_arbiter.sv
// Packet-granular weighted round-robin arbiter.
// A grant is held by its owner from the head flit to the tail flit. Each port
// may send up to weight[i] packets back to back before priority moves on.
// Port vectors are MSB-first: port 0 sits in the MSB of req/tail/gnt, and
// its weight sits in the top field of i_weights.
module c_wrr_packet_arbiter #(
    parameter int NUM_PORTS      = 8,
    parameter int WEIGHT_WIDTH   = 4,
    parameter int PORT_IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_active,
    input  logic [NUM_PORTS-1:0]              i_req,
    input  logic [NUM_PORTS-1:0]              i_tail,
    input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] i_weights,
    input  logic                              i_ready,
    output logic [NUM_PORTS-1:0]              o_gnt,
    output logic                              o_gnt_valid,
    output logic                              o_locked,
    output logic [PORT_IDX_WIDTH-1:0]         o_owner
);

    localparam logic [PORT_IDX_WIDTH-1:0] LAST_PORT = PORT_IDX_WIDTH'(NUM_PORTS - 1);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PORT_IDX_WIDTH-1:0] r_ptr;
    logic [PORT_IDX_WIDTH-1:0] r_owner;
    logic [WEIGHT_WIDTH-1:0]   r_quota;

    // Port-indexed views (element p belongs to port p)
    logic [NUM_PORTS-1:0]      w_req_p;
    logic [NUM_PORTS-1:0]      w_tail_p;
    logic [NUM_PORTS-1:0]      w_gnt_p;
    logic [WEIGHT_WIDTH-1:0]   w_weight_p [NUM_PORTS];

    logic                      w_found;
    logic [PORT_IDX_WIDTH-1:0] w_win;
    logic [PORT_IDX_WIDTH-1:0] w_sel;
    logic                      w_xfer;
    logic                      w_first;
    logic                      w_done;
    logic                      w_keep;
    logic [WEIGHT_WIDTH-1:0]   w_load_q;
    logic [WEIGHT_WIDTH-1:0]   w_base_q;
    logic [WEIGHT_WIDTH-1:0]   w_cur_q;
    logic [WEIGHT_WIDTH-1:0]   w_dec_q;

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            assign w_req_p[gp]                 = i_req[NUM_PORTS-1-gp];
            assign w_tail_p[gp]                = i_tail[NUM_PORTS-1-gp];
            assign w_weight_p[gp]              = i_weights[(NUM_PORTS-1-gp)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            assign o_gnt[NUM_PORTS-1-gp]       = w_gnt_p[gp];
        end
    endgenerate

    // Circular priority search: first requesting port at or after r_ptr
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_PORTS) v_idx = v_idx - NUM_PORTS;
            if (!w_found && w_req_p[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx[PORT_IDX_WIDTH-1:0];
            end
        end
    end

    // The port that holds (or would take) the channel this cycle
    assign w_sel   = (r_state == S_LOCKED) ? r_owner : w_win;
    assign w_xfer  = o_gnt_valid & i_ready;
    assign w_first = (r_state == S_IDLE) & w_xfer;
    assign w_done  = w_xfer & w_tail_p[w_sel];

    // A port re-winning while it still holds the pointer with quota left
    // continues its turn; anything else starts a fresh turn. Weight 0 acts as 1.
    assign w_keep   = (w_sel == r_ptr) && (r_quota != '0);
    assign w_load_q = (w_weight_p[w_sel] == '0) ? WEIGHT_WIDTH'(1) : w_weight_p[w_sel];
    assign w_base_q = w_keep ? r_quota : w_load_q;
    assign w_cur_q  = w_first ? w_base_q : r_quota;
    assign w_dec_q  = w_cur_q - WEIGHT_WIDTH'(1);

    // FSM state register; active=0 freezes everything
    always_ff @(posedge i_clk) begin
        if (i_reset)       r_state <= S_IDLE;
        else if (i_active) r_state <= w_state_nxt;
    end

    // FSM next state: lock on a non-tail head, unlock on the owner's tail
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer && !w_tail_p[w_sel]) w_state_nxt = S_LOCKED;
            S_LOCKED: if (w_done)                     w_state_nxt = S_IDLE;
            default:                                  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: zero-latency grant; locked grant follows the owner's req only
    always_comb begin
        w_gnt_p = '0;
        if (!i_reset) begin
            if (r_state == S_LOCKED)
                w_gnt_p[r_owner] = w_req_p[r_owner];
            else if (w_found)
                w_gnt_p[w_win] = 1'b1;
        end
    end

    assign o_gnt_valid = |w_gnt_p;
    assign o_locked    = (r_state == S_LOCKED) & ~i_reset;
    assign o_owner     = r_owner;

    // Pointer / quota / owner bookkeeping at packet start and completion
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_quota <= '0;
            r_owner <= '0;
        end else if (i_active) begin
            if (w_first) r_owner <= w_sel;
            if (w_done) begin
                if (w_dec_q == '0) begin
                    r_ptr   <= (w_sel == LAST_PORT) ? '0 : w_sel + PORT_IDX_WIDTH'(1);
                    r_quota <= '0;
                end else begin
                    r_ptr   <= w_sel;
                    r_quota <= w_dec_q;
                end
            end else if (w_first) begin
                r_ptr   <= w_sel;
                r_quota <= w_base_q;
            end
        end
    end

endmodule

// File: tb/tb_c_wrr_packet_arbiter.sv
// Directed bench for c_wrr_packet_arbiter (4 ports). Stimulus pushes the
// expected grant of every transfer it causes; a negedge monitor pops and
// compares on each transfer. Status outputs are checked inline.
module tb_c_wrr_packet_arbiter;

    logic        clk = 1'b0;
    logic        reset, active, ready;
    logic [3:0]  req, tail, gnt;
    logic [15:0] weights;
    logic        gnt_valid, locked;
    logic [1:0]  owner;

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_q[$];

    always #5 clk = ~clk;

    c_wrr_packet_arbiter #(
        .NUM_PORTS    (4),
        .WEIGHT_WIDTH (4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_active    (active),
        .i_req       (req),
        .i_tail      (tail),
        .i_weights   (weights),
        .i_ready     (ready),
        .o_gnt       (gnt),
        .o_gnt_valid (gnt_valid),
        .o_locked    (locked),
        .o_owner     (owner)
    );

    // Monitor: invariants every cycle, scoreboard pop on every transfer
    always @(negedge clk) begin
        logic [3:0] e;
        if (!reset) begin
            checks++;
            if (((gnt & ~req) != 4'b0) || !$onehot0(gnt)) begin
                errors++;
                $display("FAIL invariant gnt=%b req=%b", gnt, req);
            end
            if (gnt_valid && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected gnt=%b", gnt);
                end else begin
                    e = exp_q.pop_front();
                    if (gnt !== e) begin
                        errors++;
                        $display("FAIL xfer_gnt got=%b exp=%b t=%0t", gnt, e, $time);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] t, input logic rd);
        req   = r;
        tail  = t;
        ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
    endtask

    logic [3:0] seq_wrr [10];

    initial begin
        seq_wrr = '{4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                    4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0100};
        reset   = 1'b1;
        active  = 1'b1;
        ready   = 1'b1;
        req     = 4'b1111;
        tail    = 4'b1111;
        weights = 16'h2113;

        // Reset holds grants off even with every port requesting
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'(4'b0000));
        chk("rst_locked", 32'(locked), 32'd0);
        reset = 1'b0;

        // WRR with weights {2,1,1,3}, single-flit packets
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(seq_wrr[i]);
            step(4'b1111, 4'b1111, 1'b1);
            if (i == 0) begin
                chk("first_owner", 32'(owner), 32'd0);
                chk("first_locked", 32'(locked), 32'd0);
            end
        end

        // active=0: grant still shown, pointer/quota frozen
        active = 1'b0;
        exp_q.push_back(4'b0010);
        step(4'b1111, 4'b1111, 1'b1);
        exp_q.push_back(4'b0010);
        step(4'b1111, 4'b1111, 1'b1);
        active = 1'b1;
        exp_q.push_back(4'b0010);
        step(4'b1111, 4'b1111, 1'b1);
        exp_q.push_back(4'b0001);
        step(4'b1111, 4'b1111, 1'b1);

        // 3-flit packet from port 1, port 2 waiting
        do_reset();
        exp_q.push_back(4'b0100);
        step(4'b0110, 4'b0000, 1'b1);
        chk("pkt_locked", 32'(locked), 32'd1);
        chk("pkt_owner", 32'(owner), 32'd1);
        exp_q.push_back(4'b0100);
        step(4'b0110, 4'b0000, 1'b1);
        exp_q.push_back(4'b0100);
        step(4'b0110, 4'b0100, 1'b1);
        chk("pkt_unlock", 32'(locked), 32'd0);
        exp_q.push_back(4'b0010);
        step(4'b0010, 4'b0010, 1'b1);

        // Backpressure mid-packet on port 0 (weight 2)
        do_reset();
        exp_q.push_back(4'b1000);
        step(4'b1000, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(4'b1000, 4'b0000, 1'b0);
            chk("bp_gnt", 32'(gnt), 32'(4'b1000));
            chk("bp_locked", 32'(locked), 32'd1);
            chk("bp_owner", 32'(owner), 32'd0);
        end
        exp_q.push_back(4'b1000);
        step(4'b1000, 4'b1000, 1'b1);
        chk("bp_unlock", 32'(locked), 32'd0);
        exp_q.push_back(4'b1000);
        step(4'b1100, 4'b1100, 1'b1);
        exp_q.push_back(4'b0100);
        step(4'b1100, 4'b1100, 1'b1);

        // Owner bubble: port 1 drops req, port 3 must wait for the tail
        do_reset();
        exp_q.push_back(4'b0100);
        step(4'b0101, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 4'b0000, 1'b1);
            chk("bub_gnt", 32'(gnt), 32'(4'b0000));
            chk("bub_locked", 32'(locked), 32'd1);
        end
        exp_q.push_back(4'b0100);
        step(4'b0101, 4'b0100, 1'b1);
        exp_q.push_back(4'b0001);
        step(4'b0001, 4'b0001, 1'b1);

        // Weight 0 on port 3 behaves as 1, then pointer wraps to 0
        weights = 16'h2110;
        do_reset();
        exp_q.push_back(4'b0010);
        step(4'b0010, 4'b0010, 1'b1);
        exp_q.push_back(4'b0001);
        step(4'b1001, 4'b1001, 1'b1);
        exp_q.push_back(4'b1000);
        step(4'b1001, 4'b1001, 1'b1);

        // Reset mid-packet (owner 2, ptr 2) returns to IDLE with ptr 0
        exp_q.push_back(4'b0010);
        step(4'b0010, 4'b0000, 1'b1);
        chk("mid_locked", 32'(locked), 32'd1);
        chk("mid_owner", 32'(owner), 32'd2);
        reset = 1'b1;
        req   = 4'b1010;
        tail  = 4'b1010;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'(4'b0000));
        chk("mid_rst_locked", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(4'b1000);
        step(4'b1010, 4'b1010, 1'b1);
        chk("post_rst_locked", 32'(locked), 32'd0);

        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
